// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC/NPC fetch sequencer.
package pc_seq_pkg;

   // Sequencer FSM state encodings
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } seq_state_t;

   localparam int unsigned INSN_BYTES     = 4;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] RESET_NPC_DEF = 32'h0000_0004;

   // Instructions are word aligned, so the low two address bits of a target are dropped
   function automatic logic [31:0] align_target(input logic [31:0] target);
      return {target[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_npc_sequencer_adder4.sv
// Sequential-address incrementer: adds one instruction width, wrapping modulo 2^32.
module Adder_4
   import pc_seq_pkg::*;
(
   input  logic [31:0] a_i,
   output logic [31:0] sum_o
);

   assign sum_o = a_i + 32'(INSN_BYTES);

endmodule

// File: rtl/pc_npc_sequencer.sv
// PC/NPC sequencer for a delayed-branch fetch pipeline. Tracks the current and
// next fetch addresses, holds them across memory waits and hazard stalls, and
// parks a branch redirect that arrives on a non-advance cycle until it can be applied.
module pc_npc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] RESET_NPC = RESET_NPC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        branch_annul,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        le_pc,
   output logic        le_npc,
   output logic        fetch_req,
   output logic        slot_annul,
   output logic [1:0]  state
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] npc_q, npc_d;
   logic [31:0] npc_inc;
   logic        pend_q, pend_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        pend_annul_q, pend_annul_d;
   logic        slot_annul_q, slot_annul_d;

   logic        advance;
   logic        redir_apply;
   logic [31:0] redir_tgt;
   logic        redir_annul;

   Adder_4 u_adder4 (
      .a_i   (npc_q),
      .sum_o (npc_inc)
   );

   // Fetch is requested in every non-boot state; reset suppresses it in the reset cycle
   assign fetch_req = (state_q != ST_BOOT) & ~reset;
   assign advance   = fetch_req & imem_ready & ~stall;
   assign le_pc     = advance;
   assign le_npc    = advance;

   assign pc         = pc_q;
   assign npc        = npc_q;
   assign slot_annul = slot_annul_q;
   assign state      = state_q;

   // Next-state selection: boot falls through to fetch, otherwise the handshake decides
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         default: begin
            if (advance)
               state_d = ST_FETCH;
            else if (!imem_ready)
               state_d = ST_WAIT;
            else
               state_d = ST_HOLD;
         end
      endcase
   end

   // Redirect source: an already parked redirect wins over a new branch_taken
   always_comb begin
      redir_apply = pend_q | branch_taken;
      redir_tgt   = pend_q ? pend_tgt_q   : align_target(branch_target);
      redir_annul = pend_q ? pend_annul_q : branch_annul;
   end

   // Address and redirect bookkeeping; everything holds unless the fetch advances
   always_comb begin
      pc_d         = pc_q;
      npc_d        = npc_q;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;
      pend_annul_d = pend_annul_q;
      slot_annul_d = slot_annul_q;
      if (advance) begin
         // Delay slot (old npc) is always fetched next; the redirect lands in npc
         pc_d         = npc_q;
         npc_d        = redir_apply ? redir_tgt : npc_inc;
         slot_annul_d = redir_apply & redir_annul;
         pend_d       = 1'b0;
      end else if (branch_taken && !pend_q) begin
         // Park the first redirect seen while stalled; later ones are dropped
         pend_d       = 1'b1;
         pend_tgt_d   = align_target(branch_target);
         pend_annul_d = branch_annul;
      end
   end

   // State register with synchronous reset overriding all other inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         npc_q        <= RESET_NPC;
         pend_q       <= 1'b0;
         pend_tgt_q   <= 32'h0;
         pend_annul_q <= 1'b0;
         slot_annul_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         npc_q        <= npc_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
         pend_annul_q <= pend_annul_d;
         slot_annul_q <= slot_annul_d;
      end
   end

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Bench for pc_npc_sequencer: directed scenarios plus a scoreboarded random run.
module tb_pc_npc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0, stall = 1'b0, imem_ready = 1'b0;
   logic        branch_taken = 1'b0, branch_annul = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] pc, npc;
   logic        le_pc, le_npc, fetch_req, slot_annul;
   logic [1:0]  state;

   pc_npc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
      .branch_taken(branch_taken), .branch_target(branch_target), .branch_annul(branch_annul),
      .pc(pc), .npc(npc), .le_pc(le_pc), .le_npc(le_npc), .fetch_req(fetch_req),
      .slot_annul(slot_annul), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk_regs;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [1:0]  st;
      logic        slot;
      logic        le;
      logic        fr;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   logic [31:0] m_pc = 32'h0, m_npc = 32'h0, m_ptgt = 32'h0;
   logic [1:0]  m_st = 2'd0;
   logic        m_pend = 1'b0, m_pann = 1'b0, m_slot = 1'b0, m_known = 1'b0;

   // Drive one cycle at the falling edge, record expectations, step the model
   task automatic drv(input logic r, input logic s, input logic rd, input logic bt,
                      input logic [31:0] t, input logic an);
      exp_t e;
      logic fr, adv, use_r, use_an;
      logic [31:0] use_t;
      @(negedge clk);
      reset = r; stall = s; imem_ready = rd;
      branch_taken = bt; branch_target = t; branch_annul = an;
      fr  = !r && (m_st != 2'd0);
      adv = fr && rd && !s;
      e.chk_regs = m_known; e.pc = m_pc; e.npc = m_npc; e.st = m_st;
      e.slot = m_slot; e.le = adv; e.fr = fr;
      q.push_back(e);
      if (r) begin
         m_pc = 32'h0; m_npc = 32'h4; m_st = 2'd0; m_pend = 1'b0;
         m_pann = 1'b0; m_ptgt = 32'h0; m_slot = 1'b0; m_known = 1'b1;
      end else begin
         use_r  = m_pend || bt;
         use_t  = m_pend ? m_ptgt : (t & 32'hFFFF_FFFC);
         use_an = m_pend ? m_pann : an;
         if (adv) begin
            m_pc   = m_npc;
            m_npc  = use_r ? use_t : m_npc + 32'd4;
            m_slot = use_r && use_an;
            m_pend = 1'b0;
         end else if (bt && !m_pend) begin
            m_pend = 1'b1; m_ptgt = t & 32'hFFFF_FFFC; m_pann = an;
         end
         if (m_st == 2'd0 || adv) m_st = 2'd1;
         else if (!rd)            m_st = 2'd2;
         else                     m_st = 2'd3;
      end
   endtask

   // Scoreboard monitor: compares every driven cycle mid-way through the low phase
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_regs) begin
               n_chk++;
               if (pc !== e.pc || npc !== e.npc || state !== e.st || slot_annul !== e.slot)
                  $display("FAIL sb_regs t=%0t got pc=%h npc=%h st=%0d sa=%b exp pc=%h npc=%h st=%0d sa=%b",
                           $time, pc, npc, state, slot_annul, e.pc, e.npc, e.st, e.slot);
               else n_pass++;
            end
            n_chk++;
            if (le_pc !== e.le || le_npc !== e.le || fetch_req !== e.fr)
               $display("FAIL sb_comb t=%0t got le_pc=%b le_npc=%b fr=%b exp le=%b fr=%b",
                        $time, le_pc, le_npc, fetch_req, e.le, e.fr);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      drv(1, 0, 1, 0, 0, 0);
      drv(1, 0, 1, 1, 32'h40, 1);
      #1; n_chk++;
      if (fetch_req !== 1'b0 || le_pc !== 1'b0 || le_npc !== 1'b0)
         $display("FAIL reset_comb fr=%b le=%b%b exp 0/00", fetch_req, le_pc, le_npc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h0 || npc !== 32'h4 || state !== 2'd0 || slot_annul !== 1'b0 || fetch_req !== 1'b0)
         $display("FAIL reset_state pc=%h npc=%h st=%0d sa=%b fr=%b exp 0/4/0/0/0",
                  pc, npc, state, slot_annul, fetch_req);
      else n_pass++;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 1, 0, 0, 0);
         #1; n_chk++;
         if (pc !== 32'(4 * i) || npc !== 32'(4 * i + 4) || le_pc !== 1'b1 || state !== 2'd1)
            $display("FAIL seq_%0d pc=%h npc=%h le=%b st=%0d exp pc=%h le=1 st=1",
                     i, pc, npc, le_pc, state, 32'(4 * i));
         else n_pass++;
      end
   endtask

   task automatic test_branch_direct();
      drv(1, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 1, 32'h100, 0);
      #1; n_chk++;
      if (pc !== 32'h8 || npc !== 32'hC || le_pc !== 1'b1)
         $display("FAIL direct_at8 pc=%h npc=%h le=%b exp 8/c/1", pc, npc, le_pc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'hC || npc !== 32'h100 || slot_annul !== 1'b0)
         $display("FAIL direct_slot pc=%h npc=%h sa=%b exp c/100/0", pc, npc, slot_annul);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h100 || npc !== 32'h104)
         $display("FAIL direct_tgt pc=%h npc=%h exp 100/104", pc, npc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_hold_annul();
      drv(0, 1, 1, 1, 32'h200, 1);
      #1; n_chk++;
      if (pc !== 32'h108 || le_pc !== 1'b0 || fetch_req !== 1'b1)
         $display("FAIL hold_first pc=%h le=%b fr=%b exp 108/0/1", pc, le_pc, fetch_req);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         drv(0, 1, 1, 0, 0, 0);
         #1; n_chk++;
         if (state !== 2'd3 || pc !== 32'h108 || npc !== 32'h10C || le_npc !== 1'b0)
            $display("FAIL hold_frozen_%0d st=%0d pc=%h npc=%h le=%b exp 3/108/10c/0",
                     i, state, pc, npc, le_npc);
         else n_pass++;
      end
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h10C || npc !== 32'h200 || slot_annul !== 1'b1)
         $display("FAIL hold_slot pc=%h npc=%h sa=%b exp 10c/200/1", pc, npc, slot_annul);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h200 || slot_annul !== 1'b0)
         $display("FAIL hold_tgt pc=%h sa=%b exp 200/0", pc, slot_annul);
      else n_pass++;
   endtask

   task automatic test_wait_pending();
      drv(0, 0, 0, 1, 32'h200, 0);
      drv(0, 0, 0, 1, 32'h300, 0);
      #1; n_chk++;
      if (state !== 2'd2 || pc !== 32'h204 || le_pc !== 1'b0)
         $display("FAIL wait_state st=%0d pc=%h le=%b exp 2/204/0", state, pc, le_pc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h208 || npc !== 32'h200)
         $display("FAIL wait_first_wins pc=%h npc=%h exp 208/200", pc, npc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_wrap_align();
      drv(0, 0, 1, 1, 32'hFFFF_FFF8, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'hFFFF_FFF8 || npc !== 32'hFFFF_FFFC)
         $display("FAIL wrap_pre pc=%h npc=%h exp fffffff8/fffffffc", pc, npc);
      else n_pass++;
      drv(0, 0, 1, 1, 32'h103, 0);
      #1; n_chk++;
      if (npc !== 32'h0000_0000)
         $display("FAIL wrap_npc npc=%h exp 00000000", npc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h0 || npc !== 32'h100)
         $display("FAIL align_tgt pc=%h npc=%h exp 0/100", pc, npc);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_reset_mid_wait();
      drv(0, 0, 0, 1, 32'h300, 1);
      drv(0, 0, 0, 0, 0, 0);
      #1; n_chk++;
      if (state !== 2'd2)
         $display("FAIL rstmid_wait st=%0d exp 2", state);
      else n_pass++;
      drv(1, 0, 0, 1, 32'h400, 0);
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (state !== 2'd0 || pc !== 32'h0 || npc !== 32'h4 || slot_annul !== 1'b0)
         $display("FAIL rstmid_boot st=%0d pc=%h npc=%h sa=%b exp 0/0/4/0", state, pc, npc, slot_annul);
      else n_pass++;
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      drv(0, 0, 1, 0, 0, 0);
      #1; n_chk++;
      if (pc !== 32'h8 || npc !== 32'hC)
         $display("FAIL rstmid_noredir pc=%h npc=%h exp 8/c", pc, npc);
      else n_pass++;
   endtask

   task automatic test_back_to_back_random();
      for (int i = 0; i < 400; i++)
         drv(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
             $urandom, 1'($urandom_range(0, 1)));
      drv(0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_branch_direct();
      test_hold_annul();
      test_wait_pending();
      test_wrap_align();
      test_reset_mid_wait();
      test_back_to_back_random();
      repeat (3) @(negedge clk);
      #5;
      n_chk++;
      if (q.size() != 0)
         $display("FAIL sb_drain left=%0d exp 0", q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
